// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, 2-entry fetch queue toward decode, execute redirects.
// Optional macro FETCH_MISALIGN_TRAP_EN enables misaligned-target marker entries and the halt that follows them.
module fetch_unit #(
  parameter int PC_WIDTH_LENGTH   = 32,
  parameter int INST_WIDTH_LENGTH = 32,
  parameter logic [PC_WIDTH_LENGTH-1:0] RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic [PC_WIDTH_LENGTH-1:0]   PC,
  input  logic [INST_WIDTH_LENGTH-1:0] inst,
  input  logic                         redirect_valid,
  input  logic [PC_WIDTH_LENGTH-1:0]   redirect_pc,
  output logic                         f_valid,
  input  logic                         f_ready,
  output logic [INST_WIDTH_LENGTH-1:0] f_inst,
  output logic [PC_WIDTH_LENGTH-1:0]   f_pc,
  output logic                         f_misalign
);

  localparam int PW = PC_WIDTH_LENGTH;
  localparam int IW = INST_WIDTH_LENGTH;

  logic [1:0]    count;
  logic [1:0]    count_nxt;
  logic [PW-1:0] q0_pc,   q1_pc;
  logic [IW-1:0] q0_inst, q1_inst;
  logic [IW-1:0] new_inst;
  logic          pop, push, mis_pc, fetch_blocked;
  logic          load_q0_new, load_q1_new;

  function automatic logic [PW-1:0] align_pc(input logic [PW-1:0] a);
`ifdef FETCH_MISALIGN_TRAP_EN
    return a;
`else
    return {a[PW-1:2], 2'b00};
`endif
  endfunction

`ifdef FETCH_MISALIGN_TRAP_EN
  logic halted;
  logic q0_mis, q1_mis;

  assign mis_pc        = (PC[1:0] != 2'b00);
  assign fetch_blocked = halted;
  assign new_inst      = mis_pc ? '0 : inst;
  assign f_misalign    = f_valid & q0_mis;

  // Halt after enqueuing a marker; only a redirect (or reset) restarts fetch.
  always_ff @(posedge clk) begin
    if (rst || redirect_valid) halted <= 1'b0;
    else if (push && mis_pc)   halted <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (load_q0_new)  q0_mis <= mis_pc;
    else if (pop)     q0_mis <= q1_mis;
    if (load_q1_new)  q1_mis <= mis_pc;
  end
`else
  assign mis_pc        = 1'b0;
  assign fetch_blocked = 1'b0;
  assign new_inst      = inst;
  assign f_misalign    = 1'b0;
`endif

  assign f_valid = (count != 2'd0);
  assign pop     = f_valid && f_ready;
  assign push    = !fetch_blocked && !redirect_valid && ((count < 2'd2) || pop);

  // Queue is a 2-deep shift register: q0 is always the head.
  assign load_q0_new = push && ((count == 2'd0) || ((count == 2'd1) && pop));
  assign load_q1_new = push && (((count == 2'd1) && !pop) || ((count == 2'd2) && pop));

  always_comb begin
    count_nxt = count;
    unique case ({push, pop})
      2'b10:   count_nxt = count + 2'd1;
      2'b01:   count_nxt = count - 2'd1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      PC    <= align_pc(RESET_PC);
      count <= 2'd0;
    end else if (redirect_valid) begin
      PC    <= align_pc(redirect_pc);
      count <= 2'd0;
    end else begin
      if (push && !mis_pc) PC <= PC + PW'(4);
      count <= count_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (load_q0_new) begin
      q0_pc   <= PC;
      q0_inst <= new_inst;
    end else if (pop) begin
      q0_pc   <= q1_pc;
      q0_inst <= q1_inst;
    end
    if (load_q1_new) begin
      q1_pc   <= PC;
      q1_inst <= new_inst;
    end
  end

  assign f_pc   = f_valid ? q0_pc   : '0;
  assign f_inst = f_valid ? q0_inst : '0;

endmodule
